// File: rtl/conv_sched_pkg.sv
// Shared definitions for the 3x3 conv layer scheduler.
//   - FSM state encoding (IDLE, LOAD_W, STREAM, DRAIN, DONE)
//   - clog2 width helper (never returns less than 1 so it is safe as a vector width)
//   - derived-constant helpers: WPOC, IN_PIX_CNT, OPOC_S1, OPOC_S2
package conv_sched_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_W = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // weights per output channel
    function automatic int calc_wpoc(input int k, input int cin);
        return k * k * cin;
    endfunction

    // accepted input beats per output channel (one full input map pass)
    function automatic int calc_in_pix_cnt(input int w, input int h, input int cin);
        return w * h * cin;
    endfunction

    function automatic int calc_opoc_s1(input int w, input int h);
        return w * h;
    endfunction

    function automatic int calc_opoc_s2(input int w, input int h);
        return (w / 2) * (h / 2);
    endfunction

endpackage

// File: rtl/conv_sched_wt_fetch.sv
// Weight fetch for one output channel.
//   start_i        : pulse; latches oc_base_i and begins WPOC consecutive reads
//   oc_base_i      : first weight address of the channel
//   last_o         : high on the final read strobe of the burst
//   wt_rd_en_o/wt_rd_addr_o : weight RAM read port (registered)
//   wt_rd_data_i   : RAM data, valid one cycle after the strobe
//   valid_weight_o/weight_o : strobe delayed one cycle, paired with the RAM data
module conv_sched_wt_fetch
    import conv_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WPOC       = 1152,
    parameter int WADDR_W    = 18
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [WADDR_W-1:0]    oc_base_i,
    output logic                  last_o,
    output logic                  wt_rd_en_o,
    output logic [WADDR_W-1:0]    wt_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] wt_rd_data_i,
    output logic                  valid_weight_o,
    output logic [DATA_WIDTH-1:0] weight_o
);
    localparam int KW = clog2(WPOC);

    logic               run_q, run_d;
    logic [KW-1:0]      k_q, k_d;
    logic [WADDR_W-1:0] base_q, base_d;
    logic               vld_q;

    assign last_o = run_q && (k_q == KW'(WPOC - 1));

    always_comb begin
        run_d  = run_q;
        k_d    = k_q;
        base_d = base_q;
        if (start_i) begin
            run_d  = 1'b1;
            k_d    = '0;
            base_d = oc_base_i;
        end else if (run_q) begin
            if (last_o) begin
                run_d = 1'b0;
                k_d   = '0;
            end else begin
                k_d = k_q + KW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            run_q  <= 1'b0;
            k_q    <= '0;
            base_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            run_q  <= run_d;
            k_q    <= k_d;
            base_q <= base_d;
            vld_q  <= run_q;
        end
    end

    assign wt_rd_en_o     = run_q;
    assign wt_rd_addr_o   = base_q + WADDR_W'(k_q);
    assign valid_weight_o = vld_q;
    // The RAM output register supplies the data stage; gate it so the
    // weight bus reads zero whenever no weight is being presented.
    assign weight_o       = vld_q ? wt_rd_data_i : '0;

endmodule

// File: rtl/conv_3x3_layer_sched.sv
// Sequencer for one 3x3 conv layer: per output channel it loads WPOC weights
// onto the conv weight port, gates one full input-map pass into the datapath,
// counts result pixels, then moves to the next channel; pulses done at the end.
// Ports:
//   clk, reset (sync, active-high), start, stride2_cfg   : control in
//   busy, done, oc_idx, stride2                          : status / config out
//   wt_rd_en, wt_rd_addr, wt_rd_data                     : weight RAM
//   valid_weight_out, weight_out                         : conv weight port
//   src_valid, src_data, src_ready                       : pixel source
//   valid_pxl_out, pxl_out, dp_valid_out                 : datapath
// Optional build macro SCHED_PERF_CNT_EN adds perf_stall_cnt (STREAM cycles
// with no source beat offered, saturating, cleared on accepted start).
module conv_3x3_layer_sched
    import conv_sched_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int IMAGE_WIDTH     = 128,
    parameter int IMAGE_HEIGHT    = 128,
    parameter int CHANNEL_NUM_IN  = 128,
    parameter int CHANNEL_NUM_OUT = 128,
    parameter int KERNEL          = 3,
    parameter int WADDR_W         = clog2(CHANNEL_NUM_OUT * KERNEL * KERNEL * CHANNEL_NUM_IN),
    localparam int OCW            = clog2(CHANNEL_NUM_OUT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stride2_cfg,
    output logic                  busy,
    output logic                  done,
    output logic                  wt_rd_en,
    output logic [WADDR_W-1:0]    wt_rd_addr,
    input  logic [DATA_WIDTH-1:0] wt_rd_data,
    output logic                  valid_weight_out,
    output logic [DATA_WIDTH-1:0] weight_out,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_ready,
    output logic                  valid_pxl_out,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  stride2,
    input  logic                  dp_valid_out,
    output logic [OCW-1:0]        oc_idx
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]           perf_stall_cnt
`endif
);
    localparam int WPOC    = calc_wpoc(KERNEL, CHANNEL_NUM_IN);
    localparam int IN_PIX  = calc_in_pix_cnt(IMAGE_WIDTH, IMAGE_HEIGHT, CHANNEL_NUM_IN);
    localparam int OPOC_S1 = calc_opoc_s1(IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam int OPOC_S2 = calc_opoc_s2(IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam int PW      = clog2(IN_PIX);
    localparam int RW      = clog2(OPOC_S1 + 1);   // must hold OPOC itself

    logic [2:0]            state_q, state_d;
    logic [OCW-1:0]        oc_q, oc_d;
    logic [PW-1:0]         pix_q, pix_d;
    logic [RW-1:0]         res_q, res_d;
    logic                  stride2_q, stride2_d;
    logic                  vpx_q;
    logic [DATA_WIDTH-1:0] pxl_q;

    logic                  accept, res_inc, fetch_start, fetch_last;
    logic [RW-1:0]         res_sum, opoc;
    logic [WADDR_W-1:0]    fetch_base;

    assign accept  = (state_q == S_STREAM) && src_valid;
    assign res_inc = dp_valid_out && ((state_q == S_STREAM) || (state_q == S_DRAIN));
    assign res_sum = res_q + RW'(res_inc);
    assign opoc    = stride2_q ? RW'(OPOC_S2) : RW'(OPOC_S1);

    always_comb begin
        state_d     = state_q;
        oc_d        = oc_q;
        pix_d       = pix_q;
        res_d       = res_q;
        stride2_d   = stride2_q;
        fetch_start = 1'b0;
        fetch_base  = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_LOAD_W;
                    stride2_d   = stride2_cfg;
                    oc_d        = '0;
                    pix_d       = '0;
                    res_d       = '0;
                    fetch_start = 1'b1;
                end
            end
            S_LOAD_W: begin
                if (fetch_last) state_d = S_STREAM;
            end
            S_STREAM: begin
                res_d = res_sum;
                if (accept) begin
                    if (pix_q == PW'(IN_PIX - 1)) begin
                        pix_d   = '0;
                        state_d = S_DRAIN;
                    end else begin
                        pix_d = pix_q + PW'(1);
                    end
                end
            end
            S_DRAIN: begin
                res_d = res_sum;
                // >= also covers results that all arrived while still streaming
                if (res_sum >= opoc) begin
                    res_d = '0;
                    if (oc_q == OCW'(CHANNEL_NUM_OUT - 1)) begin
                        oc_d    = '0;
                        state_d = S_DONE;
                    end else begin
                        oc_d        = oc_q + OCW'(1);
                        state_d     = S_LOAD_W;
                        fetch_start = 1'b1;
                        fetch_base  = WADDR_W'(oc_d) * WADDR_W'(WPOC);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            oc_q      <= '0;
            pix_q     <= '0;
            res_q     <= '0;
            stride2_q <= 1'b0;
            vpx_q     <= 1'b0;
            pxl_q     <= '0;
        end else begin
            state_q   <= state_d;
            oc_q      <= oc_d;
            pix_q     <= pix_d;
            res_q     <= res_d;
            stride2_q <= stride2_d;
            vpx_q     <= accept;
            if (accept) pxl_q <= src_data;
        end
    end

    conv_sched_wt_fetch #(
        .DATA_WIDTH (DATA_WIDTH),
        .WPOC       (WPOC),
        .WADDR_W    (WADDR_W)
    ) u_wt_fetch (
        .clk_i          (clk),
        .reset_i        (reset),
        .start_i        (fetch_start),
        .oc_base_i      (fetch_base),
        .last_o         (fetch_last),
        .wt_rd_en_o     (wt_rd_en),
        .wt_rd_addr_o   (wt_rd_addr),
        .wt_rd_data_i   (wt_rd_data),
        .valid_weight_o (valid_weight_out),
        .weight_o       (weight_out)
    );

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign src_ready     = (state_q == S_STREAM);
    assign valid_pxl_out = vpx_q;
    assign pxl_out       = pxl_q;
    assign stride2       = stride2_q;
    assign oc_idx        = oc_q;

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            perf_q <= '0;
        end else if ((state_q == S_STREAM) && !src_valid && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_conv_3x3_layer_sched.sv
// Directed bench for conv_3x3_layer_sched at W=H=4, CIN=2, COUT=2
// (WPOC=18, 32 input beats per channel, 16 or 4 results per channel).
module tb_conv_3x3_layer_sched;
    localparam int WPOC = 18;
    localparam int NPIX = 32;
    localparam int COUT = 2;

    logic        clk = 1'b0;
    logic        reset, start, stride2_cfg;
    logic        busy, done, wt_rd_en, valid_weight_out;
    logic [5:0]  wt_rd_addr;
    logic [31:0] wt_rd_data, weight_out, src_data, pxl_out;
    logic        src_valid, src_ready, valid_pxl_out, stride2, dp_valid_out;
    logic [0:0]  oc_idx;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_3x3_layer_sched #(
        .DATA_WIDTH(32), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4),
        .CHANNEL_NUM_IN(2), .CHANNEL_NUM_OUT(2), .KERNEL(3), .WADDR_W(6)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stride2_cfg(stride2_cfg),
        .busy(busy), .done(done), .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr),
        .wt_rd_data(wt_rd_data), .valid_weight_out(valid_weight_out),
        .weight_out(weight_out), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .valid_pxl_out(valid_pxl_out), .pxl_out(pxl_out),
        .stride2(stride2), .dp_valid_out(dp_valid_out), .oc_idx(oc_idx)
`ifdef SCHED_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // synchronous weight RAM: word at address a holds A000_0000 | a
    always @(posedge clk) begin
        if (wt_rd_en) wt_rd_data <= 32'hA000_0000 | 32'(wt_rd_addr);
    end

    typedef struct {
        bit s2;       // stride2_cfg for the layer
        int gap;      // percent of cycles with src_valid low
        bit spam;     // pulse start / flip stride2_cfg while busy
        bit noise;    // drive dp_valid_out during weight loads
        bit abort;    // reset mid-STREAM of oc 1
        int exp_opoc; // hand-computed results per output channel
    } vec_t;

    vec_t vecs[4];
    vec_t abort_vec;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return {50'd0, busy, done, wt_rd_en, wt_rd_addr, valid_weight_out, weight_out,
                src_ready, valid_pxl_out, pxl_out, stride2, oc_idx};
    endfunction

    task automatic run_layer(input vec_t v);
        int c, rd_cnt, wv_cnt, pix_tot, oc, acc_oc, res_given, seq;
        int last_res_c, next_load_c;
        bit drain, ready_low_chk, prev_acc, fin, dp;
        logic [31:0] q[$];
        logic [31:0] expd;
        rd_cnt = 0; wv_cnt = 0; pix_tot = 0; oc = 0; acc_oc = 0; res_given = 0;
        seq = 0; last_res_c = -10; next_load_c = -10;
        drain = 0; ready_low_chk = 0; prev_acc = 0; fin = 0;

        @(negedge clk);
        chk("idle_before_start", busy, 0);
        start = 1; stride2_cfg = v.s2; src_valid = 0; dp_valid_out = 0;

        for (c = 1; c <= 1500 && !fin; c++) begin
            @(negedge clk);
            // ---- observe ----
            if (c == 1) chk("busy_after_start", busy, 1);
            chk("pxl_latency", valid_pxl_out, prev_acc);
            if (valid_pxl_out) begin
                if (q.size() == 0) chk("pxl_extra", 1, 0);
                else begin
                    expd = q.pop_front();
                    chk("pxl_data", pxl_out, expd);
                end
                pix_tot++;
            end
            if (wt_rd_en) begin
                if (rd_cnt % WPOC == 0) chk("oc_idx_at_load", oc_idx, rd_cnt / WPOC);
                chk("rd_addr", wt_rd_addr, rd_cnt);
                rd_cnt++;
            end
            if (valid_weight_out) begin
                chk("weight_out", weight_out, 32'hA000_0000 | wv_cnt);
                wv_cnt++;
                if (wv_cnt % WPOC == 0) begin
                    chk("ready_with_last_w", src_ready, 1);
                    chk("stride2_held", stride2, v.s2);
                end
            end
            if (ready_low_chk) begin
                chk("ready_drop", src_ready, 0);
                ready_low_chk = 0;
            end
            if (c == next_load_c) chk("next_oc_load", {wt_rd_en, oc_idx}, {1'b1, 1'(oc)});
            if (done) begin
                chk("done_timing", c, last_res_c + 1);
                chk("busy_in_done", busy, 1);
                fin = 1;
            end

            // ---- mid-layer reset ----
            if (v.abort && oc == 1 && acc_oc >= 10) begin
                reset = 1; start = 0; src_valid = 0; dp_valid_out = 0;
                @(negedge clk);
                chk("abort_outputs_zero", outs(), '0);
                reset = 0;
                repeat (4) begin
                    @(negedge clk);
                    chk("abort_quiet", {done, busy}, 0);
                end
                return;
            end

            // ---- drive ----
            start = v.spam ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (v.spam) stride2_cfg = 1'($urandom_range(0, 1));
            if (done) start = 1;   // start during DONE must be ignored

            // results: decided from counts before this cycle's accept
            dp = 0;
            if (!fin) begin
                if ((drain && res_given < v.exp_opoc) ||
                    (!drain && acc_oc >= 24 && res_given < v.exp_opoc - 1))
                    dp = (v.gap == 0) || ($urandom_range(0, 1) == 1);
                if (dp) begin
                    res_given++;
                    if (res_given == v.exp_opoc) begin
                        last_res_c = c;
                        oc++;
                        acc_oc = 0; res_given = 0; drain = 0;
                        if (oc < COUT) next_load_c = c + 1;
                    end
                end
                if (v.noise && wt_rd_en) dp = 1;   // spurious, LOAD_W must ignore it
            end
            dp_valid_out = dp;

            src_valid = !fin && ((v.gap == 0) || (int'($urandom_range(0, 99)) >= v.gap));
            src_data  = 32'h5000_0000 | seq;
            prev_acc  = src_valid && src_ready;
            if (prev_acc) begin
                q.push_back(src_data);
                seq++;
                acc_oc++;
                if (acc_oc == NPIX) begin
                    drain = 1;
                    ready_low_chk = 1;
                end
            end
        end

        if (!fin) chk("layer_timeout", 0, 1);
        @(negedge clk);
        chk("done_one_cycle", {busy, done}, 0);
        start = 0; src_valid = 0; dp_valid_out = 0;
        @(negedge clk);
        chk("idle_after_done", {busy, wt_rd_en}, 0);
        chk("reads_per_layer", rd_cnt, 2 * WPOC);
        chk("weights_per_layer", wv_cnt, 2 * WPOC);
        chk("pixels_per_layer", pix_tot, 2 * NPIX);
    endtask

    initial begin
        vecs[0] = '{s2: 1'b0, gap: 0,  spam: 1'b0, noise: 1'b0, abort: 1'b0, exp_opoc: 16};
        vecs[1] = '{s2: 1'b1, gap: 0,  spam: 1'b0, noise: 1'b0, abort: 1'b0, exp_opoc: 4};
        vecs[2] = '{s2: 1'b0, gap: 40, spam: 1'b1, noise: 1'b1, abort: 1'b0, exp_opoc: 16};
        vecs[3] = '{s2: 1'b1, gap: 60, spam: 1'b1, noise: 1'b1, abort: 1'b0, exp_opoc: 4};
        abort_vec = '{s2: 1'b1, gap: 20, spam: 1'b0, noise: 1'b0, abort: 1'b1, exp_opoc: 4};

        reset = 1; start = 0; stride2_cfg = 0; src_valid = 0; src_data = '0;
        dp_valid_out = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs_zero", outs(), '0);
        reset = 0;

        for (int i = 0; i < 4; i++) run_layer(vecs[i]);

        run_layer(abort_vec);
        run_layer(vecs[0]);   // fresh start after abort restarts at address 0

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
